cla_mod_counter: RTL and testbench

- Parametrised, synchronous modulo up/down counter whose +1/-1 datapath is a carry-lookahead incrementer/decrementer built from 4-bit lookahead groups.
- Generalises the fixed 4-bit add-by-one unit to WIDTH bits and adds direction, parallel load, enable, a programmable modulus, and a terminal-count pulse.
- Serves as the shared counting primitive for later lab blocks: timers, address generators and BCD digit chains.

---
 rtl/cla_counter_pkg.sv | 15 +
 rtl/cla_step4.sv | 22 ++
 rtl/cla_mod_counter.sv | 117 +++++++++++
 tb/tb_cla_mod_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cla_counter_pkg.sv
// rtl/cla_counter_pkg.sv - shared constants, types and helpers for the lookahead modulo counter
package cla_counter_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_step4.sv
// rtl/cla_step4.sv - 4-bit lookahead add-by-one step: result = op + cin, plus group propagate
module cla_step4
  import cla_counter_pkg::*;
(
  input  logic [GROUP_W-1:0] i_op,
  input  logic               i_cin,
  output logic [GROUP_W-1:0] o_res,
  output logic               o_p
);

  logic [GROUP_W-1:0] w_c;

  // Second operand is zero, so g = 0 and each carry is the AND of the lower bits and cin.
  assign w_c[0] = i_cin;
  assign w_c[1] = i_cin & i_op[0];
  assign w_c[2] = i_cin & i_op[0] & i_op[1];
  assign w_c[3] = i_cin & i_op[0] & i_op[1] & i_op[2];

  assign o_res = i_op ^ w_c;
  assign o_p   = &i_op;

endmodule

// File: rtl/cla_mod_counter.sv
// rtl/cla_mod_counter.sv - modulo up/down counter on a carry-lookahead +/-1 datapath
// Define CLA_MOD_COUNTER_SAT_EN to saturate at 0/LIMIT instead of wrapping.
module cla_mod_counter
  import cla_counter_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  localparam int               NG  = group_count(WIDTH);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_mod_counter: WIDTH must be a non-zero multiple of 4");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic             w_up;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_step;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gcin;
  logic             w_at_lim;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;

  assign w_up = (dir_e'(up) == DIR_UP);

  // Decrement is ~(~count + 1), so the same incrementer serves both directions.
  assign w_op = w_up ? r_count : ~r_count;

  assign w_gcin[0] = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    if (k > 0) begin : g_cin
      assign w_gcin[k] = &w_gp[k-1:0];
    end

    cla_step4 u_step (
      .i_op  (w_op[k*GROUP_W +: GROUP_W]),
      .i_cin (w_gcin[k]),
      .o_res (w_sum[k*GROUP_W +: GROUP_W]),
      .o_p   (w_gp[k])
    );
  end

  assign w_step    = w_up ? w_sum : ~w_sum;
  assign w_at_lim  = (r_count == LIM);
  assign w_at_zero = (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_count_nxt = (din > LIM) ? LIM : din;
    end else if (en) begin
      if (w_up) begin
        if (w_at_lim) begin
`ifdef CLA_MOD_COUNTER_SAT_EN
          w_count_nxt = LIM;
`else
          w_count_nxt = '0;
`endif
          w_tc_nxt    = 1'b1;
        end else begin
          w_count_nxt = w_step;
`ifdef CLA_MOD_COUNTER_SAT_EN
          w_tc_nxt    = (w_step == LIM);
`endif
        end
      end else begin
        if (w_at_zero) begin
`ifdef CLA_MOD_COUNTER_SAT_EN
          w_count_nxt = '0;
`else
          w_count_nxt = LIM;
`endif
          w_tc_nxt    = 1'b1;
        end else begin
          w_count_nxt = w_step;
`ifdef CLA_MOD_COUNTER_SAT_EN
          w_tc_nxt    = (w_step == '0);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign zero  = w_at_zero;

endmodule

// File: tb/tb_cla_mod_counter.sv
// tb/tb_cla_mod_counter.sv - directed bench for cla_mod_counter; honours CLA_MOD_COUNTER_SAT_EN
module tb_cla_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_en, a_up, a_load;
  logic [7:0] a_din, a_count;
  logic       a_tc, a_zero;

  logic        b_en, b_up, b_load;
  logic [15:0] b_din, b_count;
  logic        b_tc, b_zero;

  logic       c_en, c_up, c_load;
  logic [3:0] c_din, c_count;
  logic       c_tc, c_zero;

  cla_mod_counter #(.WIDTH(8), .LIMIT(9)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .load(a_load),
    .din(a_din), .count(a_count), .tc(a_tc), .zero(a_zero)
  );

  cla_mod_counter #(.WIDTH(16), .LIMIT(65535)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .load(b_load),
    .din(b_din), .count(b_count), .tc(b_tc), .zero(b_zero)
  );

  cla_mod_counter #(.WIDTH(4), .LIMIT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .load(c_load),
    .din(c_din), .count(c_count), .tc(c_tc), .zero(c_zero)
  );

`ifdef CLA_MOD_COUNTER_SAT_EN
  localparam logic [7:0]  UP_CNT [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  localparam logic        UP_TC  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  localparam logic [7:0]  DN_CNT [3]  = '{0, 0, 0};
  localparam logic        DN_TC  [3]  = '{1, 1, 1};
  localparam logic [7:0]  HOLD_CNT    = 8'd0;
  localparam logic [7:0]  CLAMP_NXT   = 8'd9;
  localparam logic [7:0]  S8_CNT [3]  = '{9, 9, 9};
  localparam logic        S8_TC  [3]  = '{1, 1, 1};
  localparam logic [15:0] B_TOP_UP    = 16'hFFFF;
  localparam logic [15:0] B_BOT_DN    = 16'h0000;
  localparam logic [3:0]  C_CNT [4]   = '{1, 1, 1, 1};
  localparam logic        C_TC  [4]   = '{1, 1, 1, 1};
`else
  localparam logic [7:0]  UP_CNT [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  localparam logic        UP_TC  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  localparam logic [7:0]  DN_CNT [3]  = '{0, 9, 8};
  localparam logic        DN_TC  [3]  = '{0, 1, 0};
  localparam logic [7:0]  HOLD_CNT    = 8'd8;
  localparam logic [7:0]  CLAMP_NXT   = 8'd0;
  localparam logic [7:0]  S8_CNT [3]  = '{9, 0, 1};
  localparam logic        S8_TC  [3]  = '{0, 1, 0};
  localparam logic [15:0] B_TOP_UP    = 16'h0000;
  localparam logic [15:0] B_BOT_DN    = 16'hFFFF;
  localparam logic [3:0]  C_CNT [4]   = '{1, 0, 1, 0};
  localparam logic        C_TC  [4]   = '{0, 1, 0, 1};
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_load_val(input logic [15:0] v);
    b_load = 1'b1; b_en = 1'b0; b_din = v;
    tick();
    b_load = 1'b0;
    check_eq($sformatf("b_load_%04h", v), 32'(b_count), 32'(v));
  endtask

  task automatic b_step(input logic dir, input logic [15:0] exp_cnt, input logic exp_tc);
    b_en = 1'b1; b_up = dir;
    tick();
    b_en = 1'b0;
    check_eq($sformatf("b_step_cnt_%04h", exp_cnt), 32'(b_count), 32'(exp_cnt));
    check_eq($sformatf("b_step_tc_%04h", exp_cnt), 32'(b_tc), 32'(exp_tc));
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_up = 1'b1; a_load = 1'b1; a_din = 8'h55;
    b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_din = '0;
    c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_din = '0;

    // Reset must win over load and en.
    tick();
    tick();
    check_eq("rst_count", 32'(a_count), 32'd0);
    check_eq("rst_tc",    32'(a_tc),    32'd0);
    check_eq("rst_zero",  32'(a_zero),  32'd1);
    check_eq("rst_b_count", 32'(b_count), 32'd0);

    rst_n = 1'b1; a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("up_cnt[%0d]", i),  32'(a_count), 32'(UP_CNT[i]));
      check_eq($sformatf("up_tc[%0d]", i),   32'(a_tc),    32'(UP_TC[i]));
      check_eq($sformatf("up_zero[%0d]", i), 32'(a_zero),  32'(UP_CNT[i] == 8'd0));
    end

    a_load = 1'b1; a_din = 8'd1; a_up = 1'b0;
    tick();
    a_load = 1'b0;
    check_eq("dn_load_cnt", 32'(a_count), 32'd1);
    check_eq("dn_load_tc",  32'(a_tc),    32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("dn_cnt[%0d]", i), 32'(a_count), 32'(DN_CNT[i]));
      check_eq($sformatf("dn_tc[%0d]", i),  32'(a_tc),    32'(DN_TC[i]));
    end

    a_en = 1'b0;
    tick();
    check_eq("hold_cnt", 32'(a_count), 32'(HOLD_CNT));
    check_eq("hold_tc",  32'(a_tc),    32'd0);

    a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_din = 8'd200;
    tick();
    a_load = 1'b0;
    check_eq("clamp_cnt", 32'(a_count), 32'd9);
    check_eq("clamp_tc",  32'(a_tc),    32'd0);
    tick();
    check_eq("clamp_nxt_cnt", 32'(a_count), 32'(CLAMP_NXT));
    check_eq("clamp_nxt_tc",  32'(a_tc),    32'd1);

    a_load = 1'b1; a_en = 1'b0; a_din = 8'd8;
    tick();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    check_eq("from8_load", 32'(a_count), 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("from8_cnt[%0d]", i), 32'(a_count), 32'(S8_CNT[i]));
      check_eq($sformatf("from8_tc[%0d]", i),  32'(a_tc),    32'(S8_TC[i]));
    end

    // Reset in the middle of counting aborts with no tc.
    rst_n = 1'b0;
    tick();
    check_eq("midrst_cnt",  32'(a_count), 32'd0);
    check_eq("midrst_tc",   32'(a_tc),    32'd0);
    check_eq("midrst_zero", 32'(a_zero),  32'd1);
    rst_n = 1'b1;
    tick();
    a_en = 1'b0;
    check_eq("postrst_cnt", 32'(a_count), 32'd1);
    check_eq("postrst_tc",  32'(a_tc),    32'd0);

    b_load_val(16'h0FFF);
    b_step(1'b1, 16'h1000, 1'b0);
    b_load_val(16'h1000);
    b_step(1'b0, 16'h0FFF, 1'b0);
    b_load_val(16'h00FF);
    b_step(1'b1, 16'h0100, 1'b0);
    b_load_val(16'hF0F0);
    b_step(1'b0, 16'hF0EF, 1'b0);
    b_load_val(16'hFFFF);
    b_step(1'b1, B_TOP_UP, 1'b1);
    b_load_val(16'h0000);
    b_step(1'b0, B_BOT_DN, 1'b1);

    c_en = 1'b1; c_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("lim1_cnt[%0d]", i), 32'(c_count), 32'(C_CNT[i]));
      check_eq($sformatf("lim1_tc[%0d]", i),  32'(c_tc),    32'(C_TC[i]));
    end
    c_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
